// File: rtl/rv32i_types.sv
// Shared types for the data-memory arbitration path.
package rv32i_types;

   localparam int unsigned XLEN                 = 32;
   localparam int unsigned MASK_W               = 4;
   localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [MASK_W-1:0] rmask;
      logic [MASK_W-1:0] wmask;
      logic [XLEN-1:0]   wdata;
   } dmem_req_t;

endpackage

// File: rtl/lsq_arb_perf.sv
// Grant and starvation-override event counters for the dmem arbiter; wrap on overflow.
module lsq_arb_perf #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_grant_i,
   input  logic             st_grant_i,
   input  logic             override_i,
   output logic [CNT_W-1:0] ld_grants_o,
   output logic [CNT_W-1:0] st_grants_o,
   output logic [CNT_W-1:0] overrides_o
);

   logic [CNT_W-1:0] ld_grants_q;
   logic [CNT_W-1:0] st_grants_q;
   logic [CNT_W-1:0] overrides_q;

   // Each counter advances by one on its strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_grants_q <= '0;
         st_grants_q <= '0;
         overrides_q <= '0;
      end else begin
         if (ld_grant_i) ld_grants_q <= ld_grants_q + CNT_W'(1);
         if (st_grant_i) st_grants_q <= st_grants_q + CNT_W'(1);
         if (override_i) overrides_q <= overrides_q + CNT_W'(1);
      end
   end

   assign ld_grants_o = ld_grants_q;
   assign st_grants_o = st_grants_q;
   assign overrides_o = overrides_q;

endmodule

// File: rtl/lsq_dmem_arbiter.sv
// Sequences the single data-memory port between load issue and store commit,
// one transaction in flight, loads preferred unless the store is urgent.
module lsq_dmem_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned TAG_W        = 5,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              ld_req_valid,
   output logic              ld_req_ready,
   input  logic [XLEN-1:0]   ld_addr,
   input  logic [MASK_W-1:0] ld_rmask,
   input  logic [TAG_W-1:0]  ld_tag,
   output logic              ld_resp_valid,
   output logic [XLEN-1:0]   ld_resp_data,
   output logic [TAG_W-1:0]  ld_resp_tag,
   input  logic              st_req_valid,
   output logic              st_req_ready,
   input  logic [XLEN-1:0]   st_addr,
   input  logic [MASK_W-1:0] st_wmask,
   input  logic [XLEN-1:0]   st_wdata,
   input  logic              st_q_full,
   output logic              st_done,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [MASK_W-1:0] dmem_rmask,
   output logic [MASK_W-1:0] dmem_wmask,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_resp,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic [CNT_W-1:0]  perf_ld_grants,
   output logic [CNT_W-1:0]  perf_st_grants,
   output logic [CNT_W-1:0]  perf_starve_overrides
);

   localparam int unsigned     SC_W       = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [XLEN-1:0] WORD_ALIGN = ~XLEN'(3);

   arb_state_t       state_q, state_d;
   logic [SC_W-1:0]  starve_q, starve_d;
   logic             kill_q, kill_d;
   dmem_req_t        req_q, req_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             ld_resp_valid_q, ld_resp_valid_d;
   logic [XLEN-1:0]  ld_resp_data_q, ld_resp_data_d;
   logic [TAG_W-1:0] ld_resp_tag_q, ld_resp_tag_d;
   logic             st_done_q, st_done_d;

   logic ld_ok, st_urgent, st_win;
   logic ld_ready_c, st_ready_c;
   logic ld_grant, st_grant, st_override;

   // Priority decision: store only when urgent or when no load can go.
   assign ld_ok     = ld_req_valid & ~flush;
   assign st_urgent = st_q_full | (starve_q >= STARVE_MAX);
   assign st_win    = st_req_valid & (st_urgent | ~ld_ok);

   // Next-state, grant and completion logic.
   always_comb begin
      state_d         = state_q;
      starve_d        = starve_q;
      kill_d          = kill_q;
      req_d           = req_q;
      req_d.rmask     = '0;
      req_d.wmask     = '0;
      tag_d           = tag_q;
      ld_resp_valid_d = 1'b0;
      ld_resp_data_d  = ld_resp_data_q;
      ld_resp_tag_d   = ld_resp_tag_q;
      st_done_d       = 1'b0;
      ld_ready_c      = 1'b0;
      st_ready_c      = 1'b0;
      ld_grant        = 1'b0;
      st_grant        = 1'b0;
      st_override     = 1'b0;

      unique case (state_q)
         IDLE: begin
            kill_d = 1'b0;
            if (st_win) begin
               st_ready_c  = 1'b1;
               st_grant    = 1'b1;
               st_override = ld_ok;
               starve_d    = '0;
               req_d.addr  = st_addr & WORD_ALIGN;
               req_d.wmask = st_wmask;
               req_d.wdata = st_wdata;
               state_d     = ST_WAIT;
            end else begin
               if (st_req_valid && (starve_q < STARVE_MAX)) begin
                  starve_d = starve_q + SC_W'(1);
               end
               if (ld_ok) begin
                  ld_ready_c  = 1'b1;
                  ld_grant    = 1'b1;
                  req_d.addr  = ld_addr & WORD_ALIGN;
                  req_d.rmask = ld_rmask;
                  tag_d       = ld_tag;
                  state_d     = LD_WAIT;
               end
            end
         end
         LD_WAIT: begin
            if (flush) kill_d = 1'b1;
            if (dmem_resp) begin
               ld_resp_valid_d = ~kill_q & ~flush;
               ld_resp_data_d  = dmem_rdata;
               ld_resp_tag_d   = tag_q;
               kill_d          = 1'b0;
               state_d         = IDLE;
            end
         end
         ST_WAIT: begin
            if (dmem_resp) begin
               st_done_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         starve_q        <= '0;
         kill_q          <= 1'b0;
         req_q           <= '0;
         tag_q           <= '0;
         ld_resp_valid_q <= 1'b0;
         ld_resp_data_q  <= '0;
         ld_resp_tag_q   <= '0;
         st_done_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         starve_q        <= starve_d;
         kill_q          <= kill_d;
         req_q           <= req_d;
         tag_q           <= tag_d;
         ld_resp_valid_q <= ld_resp_valid_d;
         ld_resp_data_q  <= ld_resp_data_d;
         ld_resp_tag_q   <= ld_resp_tag_d;
         st_done_q       <= st_done_d;
      end
   end

   // Readies are combinational and held low while in reset.
   assign ld_req_ready  = ld_ready_c & rst_n;
   assign st_req_ready  = st_ready_c & rst_n;
   assign ld_resp_valid = ld_resp_valid_q;
   assign ld_resp_data  = ld_resp_data_q;
   assign ld_resp_tag   = ld_resp_tag_q;
   assign st_done       = st_done_q;
   assign dmem_addr     = req_q.addr;
   assign dmem_rmask    = req_q.rmask;
   assign dmem_wmask    = req_q.wmask;
   assign dmem_wdata    = req_q.wdata;

   lsq_arb_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_grant_i  (ld_grant),
      .st_grant_i  (st_grant),
      .override_i  (st_override),
      .ld_grants_o (perf_ld_grants),
      .st_grants_o (perf_st_grants),
      .overrides_o (perf_starve_overrides)
   );

   // Memory must not complete while nothing is outstanding; such a response is dropped.
   a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst_n)
      !(dmem_resp && (state_q == IDLE)))
      else $warning("dmem_resp while idle was dropped");

endmodule

// File: doc/lsq_dmem_arbiter.md
Name: lsq_dmem_arbiter

Overview:
- Sequences the single data-memory port between two requesters: the load reservation station issue path and the store queue commit path.
- Allows one memory transaction in flight at a time.
- Load priority by default. A store is granted instead when the store queue is full, or when the store has been denied for STARVE_LIMIT arbitration cycles.
- Handles pipeline flush for in-flight loads and exposes grant/override performance counters.

Parameters:
- TAG_W, 5: width of the load tag (ROB index) carried from request to response.
- STARVE_LIMIT, 8: consecutive denied IDLE cycles after which a pending store beats a pending load.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; kills loads.
- ld_req_valid  in  1  load issue request.
- ld_req_ready  out  1  load accepted this cycle (combinational).
- ld_addr  in  32  load byte address.
- ld_rmask  in  4  load byte mask.
- ld_tag  in  TAG_W  load tag.
- ld_resp_valid  out  1  load data return, one cycle.
- ld_resp_data  out  32  raw memory word.
- ld_resp_tag  out  TAG_W  tag of the returned load.
- st_req_valid  in  1  committed store at the store-queue head.
- st_req_ready  out  1  store accepted this cycle (combinational).
- st_addr  in  32  store address.
- st_wmask  in  4  store byte mask.
- st_wdata  in  32  store data, already lane-aligned.
- st_q_full  in  1  store queue full; marks the store as urgent.
- st_done  out  1  store written to memory, one cycle; store queue pops its head.
- dmem_addr  out  32  memory address; bits [1:0] are forced to 0.
- dmem_rmask  out  4  read mask.
- dmem_wmask  out  4  write mask.
- dmem_wdata  out  32  write data.
- dmem_resp  in  1  memory completion.
- dmem_rdata  in  32  memory read data, valid with dmem_resp.
- perf_ld_grants  out  CNT_W  count of load grants.
- perf_st_grants  out  CNT_W  count of store grants.
- perf_starve_overrides  out  CNT_W  grants where a store beat a valid load.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. starve_cnt, kill and all perf counters clear.
  - All outputs are 0: dmem masks/addr/wdata, ld_resp_*, st_done, both readies.
- FSM states: IDLE, LD_WAIT, ST_WAIT. Readies may be high only in IDLE.
- Arbitration in IDLE:
  - ld_ok = ld_req_valid & ~flush.
  - st_urgent = st_q_full | (starve_cnt >= STARVE_LIMIT).
  - Store wins if st_req_valid & (st_urgent | ~ld_ok). Otherwise the load wins if ld_ok. At most one ready is high.
- Grant in cycle N:
  - The request fields are latched into output registers.
  - dmem_*mask is nonzero for exactly one cycle, N+1. Address and data are held until the response arrives.
  - State moves to LD_WAIT or ST_WAIT at N+1.
- Completion:
  - dmem_resp may arrive at N+2 or later, in cycle M.
  - LD_WAIT: in M+1, ld_resp_valid=1 with dmem_rdata latched and the latched tag, unless kill is set. State returns to IDLE in M+1, so a new grant is legal in M+1.
  - ST_WAIT: st_done=1 in M+1; state returns to IDLE.
- starve_cnt:
  - +1 on each IDLE cycle where st_req_valid=1 and the store is not granted; saturates at STARVE_LIMIT.
  - Cleared on store grant.
  - Holds outside IDLE.
- Flush:
  - flush in IDLE blocks load grants; stores are unaffected.
  - flush in LD_WAIT, or in the grant cycle of a load, sets kill. The FSM still waits for dmem_resp, then suppresses ld_resp_valid.
  - kill clears on return to IDLE.
  - flush in ST_WAIT has no effect.
- dmem_resp while in IDLE is ignored. This is a protocol violation and is flagged by assertion.
- Simultaneous dmem_resp and flush in LD_WAIT: the response is suppressed.
- Perf counters:
  - perf_starve_overrides increments when the store wins while ld_ok=1.
  - Counters wrap at 2^CNT_W.

Decomposition:
- Shared package rv32i_types gets:
  - arb_state_t, the enum {IDLE, LD_WAIT, ST_WAIT};
  - struct dmem_req_t {addr, rmask, wmask, wdata};
  - the default STARVE_LIMIT constant.
- Sub-module: lsq_arb_perf, holding the three counters with increment strobes. All other logic stays flat.

Test Plan:
1. Load only: ld_req_valid with addr 0x1000_0006, rmask 4'b1100, tag 3; dmem_resp 3 cycles later with rdata 0xDEADBEEF.
   -> dmem_rmask=4'b1100 and dmem_addr=0x1000_0004 for one cycle; ld_resp_valid one cycle with data 0xDEADBEEF, tag 3; perf_ld_grants=1.
2. Load vs store, not urgent: both valid continuously, STARVE_LIMIT=8, 1-cycle memory.
   -> 8 consecutive load grants, then a store grant (perf_starve_overrides=1); starve_cnt returns to 0.
3. st_q_full=1 with both valid.
   -> Store granted first; dmem_wmask equals st_wmask; st_done pulses once after dmem_resp.
4. flush asserted 1 cycle after a load grant; dmem_resp arrives 4 cycles later.
   -> No ld_resp_valid; FSM returns to IDLE; the next load is granted normally.
5. flush in IDLE with both valid.
   -> Store granted, ld_req_ready=0; perf_starve_overrides unchanged.
6. rst_n pulled low during LD_WAIT, then dmem_resp arrives after release.
   -> All outputs 0 immediately; stray dmem_resp ignored; counters read 0.
